// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling unit.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Bit value replicated across the data path on reset.
  localparam logic POOL_DATA_RST = 1'b0;

  // Ceiling log2 for elaboration-time window sizing.
  function automatic int unsigned pool_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_max_cmp.sv
// Combinational maximum of two samples; ties return a_i so the running value is kept.
module pool_max_cmp #(
  parameter int unsigned DATA_W = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] max_c_o
);

  logic b_gt_a_c;

  always_comb begin
    b_gt_a_c = 1'b0;
    if (SIGNED) b_gt_a_c = $signed(b_i) > $signed(a_i);
    else        b_gt_a_c = b_i > a_i;
    max_c_o = b_gt_a_c ? b_i : a_i;
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming max/mean pooler over WIN-beat windows with valid/ready on both sides.
// Define POOL_AVG_EN to build the average mode; otherwise the unit is max-only.
module pool_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WIN    = 4,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(WIN)-1:0]  win_cnt
);

  localparam int unsigned LOG2W = pool_log2(WIN);
  localparam int unsigned CNT_W = $clog2(WIN);
`ifdef POOL_AVG_EN
  localparam int unsigned ACC_W = DATA_W + LOG2W;
`else
  localparam int unsigned ACC_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  in_ext_c;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] max_c;
  logic              first_c, last_c, accept_c;

  pool_max_cmp #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_max_cmp (
    .a_i     (acc_q[DATA_W-1:0]),
    .b_i     (in_data),
    .max_c_o (max_c)
  );

`ifdef POOL_AVG_EN
  pool_mode_e       mode_q, mode_d;
  logic [ACC_W-1:0] sum_c;

  // Widen the sample so the running sum cannot overflow.
  assign in_ext_c = SIGNED ? {{LOG2W{in_data[DATA_W-1]}}, in_data}
                           : {{LOG2W{1'b0}}, in_data};
  assign sum_c    = acc_q + in_ext_c;
`else
  logic unused_mode;

  assign in_ext_c    = in_data;
  assign unused_mode = mode;
`endif

  assign first_c  = (cnt_q == '0);
  assign last_c   = (cnt_q == CNT_LAST);
  // Only the closing beat waits for the output slot; earlier beats always flow.
  assign in_ready = rst && !(last_c && out_valid_q && !out_ready);
  assign accept_c = in_valid && in_ready && !clr;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef POOL_AVG_EN
    mode_d      = mode_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (first_c) begin
        acc_d  = in_ext_c;
`ifdef POOL_AVG_EN
        mode_d = pool_mode_e'(mode);
`endif
      end else if (!last_c) begin
`ifdef POOL_AVG_EN
        acc_d = (mode_q == POOL_AVG) ? sum_c : ACC_W'(max_c);
`else
        acc_d = max_c;
`endif
      end else begin
        out_valid_d = 1'b1;
`ifdef POOL_AVG_EN
        // Upper DATA_W bits of the widened sum equal the shifted mean for either signedness.
        out_data_d  = (mode_q == POOL_AVG) ? sum_c[ACC_W-1 -: DATA_W] : max_c;
`else
        out_data_d  = max_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= {ACC_W{POOL_DATA_RST}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{POOL_DATA_RST}};
`ifdef POOL_AVG_EN
      mode_q      <= POOL_MAX;
`endif
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_cnt   = cnt_q;

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: signed and unsigned instances share one stimulus stream.
module tb_pool_stream;

  localparam int unsigned DW  = 32;
  localparam int unsigned WIN = 4;

  logic          clk = 1'b0;
  logic          rst, clr, mode, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [DW-1:0] out_data_s, out_data_u;
  logic [1:0]    win_cnt_s, win_cnt_u;

  int n_checks = 0;
  int n_fail   = 0;

  pool_stream #(.DATA_W(DW), .WIN(WIN), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .win_cnt(win_cnt_s)
  );

  pool_stream #(.DATA_W(DW), .WIN(WIN), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .win_cnt(win_cnt_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid_s), 32'd0);
    check("rst_data", out_data_s, 32'd0);
    check("rst_cnt", 32'(win_cnt_s), 32'd0);
    check("rst_ready", 32'(in_ready_s), 32'd0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", 32'(in_ready_s), 32'd1);

    // Max signed: -5,3,-1,2
    send4(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'd2);
    check("max_s_valid", 32'(out_valid_s), 32'd1);
    check("max_s_data", out_data_s, 32'd3);
    check("max_u_data", out_data_u, 32'hFFFF_FFFF);
    check("max_s_cnt", 32'(win_cnt_s), 32'd0);
    tick();
    check("max_s_valid_1cyc", 32'(out_valid_s), 32'd0);

    // Signed vs unsigned compare
    send4(32'h8000_0000, 32'd1, 32'd0, 32'd0);
    check("sgn_s_data", out_data_s, 32'd1);
    check("sgn_u_data", out_data_u, 32'h8000_0000);
    tick();

`ifdef POOL_AVG_EN
    mode = 1'b1;
    send4(32'd4, 32'd8, 32'd12, 32'd16);
    check("avg_s_data", out_data_s, 32'd10);
    check("avg_u_data", out_data_u, 32'd10);
    send4(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    check("avg_neg_s", out_data_s, 32'hFFFF_FFFD);
    check("avg_neg_u", out_data_u, 32'hFFFF_FFFD);
    send(32'd4);
    mode = 1'b0;
    send(32'd8); send(32'd12); send(32'd16);
    check("avg_mode_latch", out_data_s, 32'd10);
    tick();
`else
    mode = 1'b1;
    send4(32'd4, 32'd8, 32'd12, 32'd16);
    check("maxonly_s_data", out_data_s, 32'd16);
    check("maxonly_u_data", out_data_u, 32'd16);
    mode = 1'b0;
    tick();
`endif

    // Back-pressure across two windows
    out_ready = 1'b0;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    check("bp_r1_valid", 32'(out_valid_s), 32'd1);
    check("bp_r1_data", out_data_s, 32'd4);
    send(32'd5);
    check("bp_cnt1", 32'(win_cnt_s), 32'd1);
    send(32'd6);
    send(32'd7);
    check("bp_cnt3", 32'(win_cnt_s), 32'd3);
    in_valid = 1'b1;
    in_data  = 32'd8;
    @(negedge clk);
    check("bp_ready_low", 32'(in_ready_s), 32'd0);
    tick(); tick();
    check("bp_cnt_hold", 32'(win_cnt_s), 32'd3);
    check("bp_r1_hold", out_data_s, 32'd4);
    check("bp_valid_hold", 32'(out_valid_s), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_comb", 32'(in_ready_s), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_r2_valid", 32'(out_valid_s), 32'd1);
    check("bp_r2_data", out_data_s, 32'd8);
    check("bp_r2_cnt", 32'(win_cnt_s), 32'd0);
    tick();
    check("bp_drained", 32'(out_valid_s), 32'd0);

    // Clear drops the partial window and the beat presented with it
    send(32'd50);
    send(32'd60);
    check("clr_cnt_pre", 32'(win_cnt_s), 32'd2);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'd100;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_cnt", 32'(win_cnt_s), 32'd0);
    check("clr_no_valid", 32'(out_valid_s), 32'd0);
    send4(32'd7, 32'd1, 32'd9, 32'd4);
    check("clr_valid", 32'(out_valid_s), 32'd1);
    check("clr_data", out_data_s, 32'd9);
    check("clr_data_u", out_data_u, 32'd9);
    tick();

    // Reset mid-window with a pending result
    out_ready = 1'b0;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    send(32'd5);
    send(32'd6);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", 32'(in_ready_s), 32'd0);
    @(posedge clk);
    #1;
    check("mrst_valid", 32'(out_valid_s), 32'd0);
    check("mrst_data", out_data_s, 32'd0);
    check("mrst_cnt", 32'(win_cnt_s), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    send4(32'd10, 32'd20, 32'd30, 32'd40);
    check("post_rst_valid", 32'(out_valid_s), 32'd1);
    check("post_rst_data", out_data_s, 32'd40);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
# pool_stream

Parametrised streaming pooling unit: reduces every WIN consecutive accepted samples to one result, either maximum or mean (power-of-two window). It sits between the convolution/activation stage and the next layer's buffer. It replaces the fixed 4-sample max pooler with:
- configurable width, window, signedness and mode;
- valid/ready flow control on both sides;
- a registered, back-pressurable output.

## Interface
Parameters:
- DATA_W, 32, sample and result width in bits
- WIN, 4, samples per window; power of two, 2..256
- SIGNED, 1, 1 = two's-complement compare/shift, 0 = unsigned

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge)
- clr  in  1  synchronous clear of the partial window; does not affect a pending output
- mode  in  1  0 = max, 1 = average; sampled on the first beat of each window
- in_valid  in  1  input sample valid
- in_ready  out  1  input can be accepted this cycle
- in_data  in  DATA_W  input sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  pooled result
- win_cnt  out  $clog2(WIN)  beats accepted in the current window

## Operation
- Accept = in_valid && in_ready. cnt counts accepts 0..WIN-1 and wraps to 0 after the last beat.
- First beat (cnt==0): acc loads in_data and mode_q latches mode. mode changes mid-window are ignored.
- Max mode, beats 1..WIN-1: acc = max(acc, in_data). Comparison is signed iff SIGNED=1. Ties keep acc.
- Avg mode, beats 1..WIN-1: acc = acc + in_data. acc is DATA_W+log2(WIN) bits wide, sign-extended iff SIGNED, so it never overflows.
- Last beat (cnt==WIN-1): the result is formed from acc and in_data and registered into out_data; out_valid is set.
  - Max result: the final maximum.
  - Avg result: the full sum shifted right by log2(WIN). Shift is arithmetic when SIGNED=1 (rounds toward −∞), logical when SIGNED=0. Low DATA_W bits are kept.
- in_ready = rst && !(cnt==WIN-1 && out_valid && !out_ready). Non-last beats are always accepted, even while the output is stalled.
- Output handshake: out_valid && out_ready clears out_valid, unless a new result is registered in the same cycle; then out_valid stays 1 and out_data updates.
- out_data holds stable while out_valid && !out_ready.
- clr: cnt←0, acc←0, and any beat presented that cycle is dropped (in_ready is still reported but the accept is ignored). clr outranks accept.
- Reset: cnt=0, acc=0, mode_q=0, out_valid=0, out_data=0, win_cnt=0, in_ready=0 while rst==0.
- Reset mid-window discards the partial window and any pending result.

## Timing
- Latency: last beat accepted at edge t → out_valid=1 and out_data valid after edge t (visible cycle t+1).
- Throughput: one result per WIN accepted beats. There are no bubbles when out_ready is held 1.
- in_ready depends combinationally on out_ready. No other comb paths run from inputs to outputs.
- win_cnt equals the registered cnt.

## Configuration
- Macro POOL_AVG_EN:
  - Defined: average mode is built as described; acc is DATA_W+log2(WIN) bits.
  - Undefined: max-only. The mode port stays present but is ignored (treated as 0), mode_q and the adder are removed, and acc is DATA_W bits.

## Structure
- Shared package pool_pkg:
  - enum pool_mode_e {POOL_MAX=0, POOL_AVG=1};
  - localparam helper for log2(WIN);
  - reset value constant for the data path.
- Sub-module pool_max_cmp (params DATA_W, SIGNED): combinational a/b → max(a,b).
- Top level holds the cnt/acc/output register logic and the optional adder.

## Test plan
All scenarios use DATA_W=32 and WIN=4.
- Max signed: mode=0, beats -5,3,-1,2 with out_ready=1 → one result 3, out_valid high exactly one cycle, win_cnt back to 0.
- Signed vs unsigned: beats 0x80000000,1,0,0.
  - SIGNED=1 → 1.
  - SIGNED=0 → 0x80000000.
- Average (POOL_AVG_EN):
  - 4,8,12,16 → 10.
  - SIGNED=1, -1,-2,-3,-4 → -3.
  - mode toggled to 0 after beat 1 → still average.
- Back-pressure: two windows streamed back-to-back with out_ready=0.
  - Beats 0..2 of window 2 are accepted.
  - in_ready=0 on its beat 3.
  - First result holds.
  - Raising out_ready drains result 1; result 2 appears the next cycle with no loss.
- Clear/reset: clr after 2 beats, then 7,1,9,4 → 9. rst=0 mid-window → out_valid=0, out_data=0, in_ready=0 during reset.
- Max-only build (no POOL_AVG_EN): mode=1 with beats 4,8,12,16 → 16.
